// File: rtl/stream_disp_route_pkg.sv
// rtl/stream_disp_route_pkg.sv - shared state type and width helper for the packet router
package stream_disp_route_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } route_state_e;

  // Destination field width; a 2-output router still needs one bit.
  function automatic int dest_w(input int out_nb);
    return (out_nb <= 2) ? 1 : $clog2(out_nb);
  endfunction

endpackage

// File: rtl/stream_disp_route_skid.sv
// rtl/stream_disp_route_skid.sv - 2-entry elastic buffer feeding one router output
module stream_disp_route_skid #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_vld,
  input  logic             out_rdy
);

  logic [WIDTH-1:0] mem [2];
  logic [1:0]       cnt;
  logic             wr_ptr;
  logic             rd_ptr;
  logic             push;
  logic             pop;

  // Both handshake outputs come from registered occupancy only.
  assign in_rdy   = (cnt != 2'd2);
  assign out_vld  = (cnt != 2'd0);
  assign out_data = mem[rd_ptr];
  assign push     = in_vld & in_rdy;
  assign pop      = out_vld & out_rdy;

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      cnt    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/stream_disp_route.sv
// rtl/stream_disp_route.sv - steers length-delimited packets to one of OUT_NB output streams
module stream_disp_route
  import stream_disp_route_pkg::*;
#(
  parameter int  OP_W   = 32,
  parameter int  COEF   = 8,
  parameter int  OUT_NB = 4,
  parameter int  LEN_W  = 8,
  localparam int DW     = dest_w(OUT_NB)
) (
  input  logic                                    clk,
  input  logic                                    a_rst,
  input  logic [COEF-1:0][OP_W-1:0]               in_data,
  input  logic [DW-1:0]                           in_dest,
  input  logic [LEN_W-1:0]                        in_len,
  input  logic                                    in_vld,
  output logic                                    in_rdy,
  output logic [OUT_NB-1:0][COEF-1:0][OP_W-1:0]   out_data,
  output logic [OUT_NB-1:0]                       out_vld,
  input  logic [OUT_NB-1:0]                       out_rdy,
  output logic                                    busy,
  output logic                                    err_dest
);

  localparam int WIDTH = COEF * OP_W;

  route_state_e      state;
  route_state_e      state_nxt;
  logic [LEN_W-1:0]  rem;
  logic [DW-1:0]     dest_q;
  logic [DW-1:0]     sel;
  logic              hdr_legal;
  logic              fwd_word;
  logic              sel_rdy;
  logic              accept;
  logic [OUT_NB-1:0] skid_rdy;

  assign hdr_legal = ({1'b0, in_dest} < (DW+1)'(OUT_NB));
  // The header carries the destination; later words follow the latched one.
  assign sel       = (state == IDLE) ? in_dest : dest_q;
  assign busy      = (state != IDLE);
  assign accept    = in_vld & in_rdy;

  always_comb begin
    sel_rdy = 1'b0;
    for (int d = 0; d < OUT_NB; d++) begin
      if (sel == DW'(d)) sel_rdy = skid_rdy[d];
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept && in_len != '0) state_nxt = hdr_legal ? FWD : DROP;
      FWD, DROP: if (accept && rem == LEN_W'(1)) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_rdy   = 1'b1;
    fwd_word = 1'b0;
    case (state)
      IDLE: begin
        fwd_word = hdr_legal;
        in_rdy   = hdr_legal ? sel_rdy : 1'b1;
      end
      FWD: begin
        fwd_word = 1'b1;
        in_rdy   = sel_rdy;
      end
      default: begin
        fwd_word = 1'b0;
        in_rdy   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      rem      <= '0;
      dest_q   <= '0;
      err_dest <= 1'b0;
    end else begin
      // Illegal headers are always accepted, so in_vld alone marks the drop.
      err_dest <= (state == IDLE) && in_vld && !hdr_legal;
      if (accept) begin
        if (state == IDLE) begin
          rem <= in_len;
          if (hdr_legal) dest_q <= in_dest;
        end else begin
          rem <= rem - LEN_W'(1);
        end
      end
    end
  end

  for (genvar d = 0; d < OUT_NB; d++) begin : g_out
    logic vld_d;
    assign vld_d = in_vld & fwd_word & (sel == DW'(d));

    stream_disp_route_skid #(
      .WIDTH (WIDTH)
    ) u_skid (
      .clk      (clk),
      .a_rst    (a_rst),
      .in_data  (in_data),
      .in_vld   (vld_d),
      .in_rdy   (skid_rdy[d]),
      .out_data (out_data[d]),
      .out_vld  (out_vld[d]),
      .out_rdy  (out_rdy[d])
    );
  end

endmodule
